// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional misalignment checking is enabled with DMEM_ARB_ALIGN_CHECK_EN.
package dmem_arb_pkg;

  localparam int unsigned STARVE_CNT_W = 4;
  localparam int unsigned REQ_ADDR_W   = 32;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_CORE = 2'd1,
    PORT_AUX  = 2'd2
  } port_sel_e;

  // Address is carried at a fixed maximum width and narrowed at the memory port.
  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [63:0]           wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Fixed-priority grant for the core port with a saturating starvation
// counter that forces the auxiliary port through after STARVE_LIMIT refusals.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset_b,
  input  logic      req0_valid_i,
  input  logic      req1_valid_i,
  output port_sel_e sel_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_q;
  logic [STARVE_CNT_W-1:0] starve_d;

  always_comb begin
    sel_o    = PORT_NONE;
    starve_d = starve_q;

    // No grant is issued while reset is held, so ready stays low.
    if (!reset_b) begin
      sel_o = PORT_NONE;
    end else if (req1_valid_i && (starve_q == LIMIT)) begin
      sel_o = PORT_AUX;
    end else if (req0_valid_i) begin
      sel_o = PORT_CORE;
    end else if (req1_valid_i) begin
      sel_o = PORT_AUX;
    end

    if (!req1_valid_i || (sel_o == PORT_AUX)) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 64-bit data memory: grant,
// request muxing and registered load responses. Option: DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH = 10,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic                       req0_write,
  input  logic [DMEM_ADDR_WIDTH-1:0] req0_addr,
  input  logic [63:0]                req0_wdata,
  output logic                       rsp0_valid,
  output logic [63:0]                rsp0_rdata,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic                       req1_write,
  input  logic [DMEM_ADDR_WIDTH-1:0] req1_addr,
  input  logic [63:0]                req1_wdata,
  output logic                       rsp1_valid,
  output logic [63:0]                rsp1_rdata,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]                mem_din,
  output logic                       mem_read,
  output logic                       mem_write,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic                       err0,
  output logic                       err1,
`endif
  input  logic [63:0]                mem_dout
);

  port_sel_e sel;
  dmem_req_t req0_s;
  dmem_req_t req1_s;
  dmem_req_t req_sel;
  logic      misalign;
  logic      load0;
  logic      load1;

  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [63:0] rsp0_rdata_q;
  logic [63:0] rsp1_rdata_q;

  dmem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk         (clk),
    .reset_b     (reset_b),
    .req0_valid_i(req0_valid),
    .req1_valid_i(req1_valid),
    .sel_o       (sel)
  );

  always_comb begin
    req0_s = '{write: req0_write, addr: REQ_ADDR_W'(req0_addr), wdata: req0_wdata};
    req1_s = '{write: req1_write, addr: REQ_ADDR_W'(req1_addr), wdata: req1_wdata};
    req_sel = '0;
    case (sel)
      PORT_CORE: req_sel = req0_s;
      PORT_AUX:  req_sel = req1_s;
      default:   req_sel = '0;
    endcase
  end

  generate
    if (DMEM_ADDR_WIDTH < REQ_ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_sel.addr[REQ_ADDR_W-1:DMEM_ADDR_WIDTH];
    end
  endgenerate

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (req_sel.addr[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  assign req0_ready = (sel == PORT_CORE);
  assign req1_ready = (sel == PORT_AUX);

  // A misaligned transfer is still accepted but never reaches the memory.
  assign mem_addr  = req_sel.addr[DMEM_ADDR_WIDTH-1:0];
  assign mem_din   = req_sel.wdata;
  assign mem_read  = (sel != PORT_NONE) && !req_sel.write && !misalign;
  assign mem_write = (sel != PORT_NONE) &&  req_sel.write && !misalign;

  assign load0 = req0_ready && !req_sel.write && !misalign;
  assign load1 = req1_ready && !req_sel.write && !misalign;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= load0;
      rsp1_valid_q <= load1;
      if (load0) rsp0_rdata_q <= mem_dout;
      if (load1) rsp1_rdata_q <= mem_dout;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err0_q;
  logic err1_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= req0_ready && misalign;
      err1_q <= req1_ready && misalign;
    end
  end

  assign err0 = err0_q;
  assign err1 = err1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory, a reference
// memory image and per-port response scoreboards.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_b;
  logic        req0_valid, req0_ready, req0_write;
  logic [9:0]  req0_addr;
  logic [63:0] req0_wdata;
  logic        rsp0_valid;
  logic [63:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [9:0]  req1_addr;
  logic [63:0] req1_wdata;
  logic        rsp1_valid;
  logic [63:0] rsp1_rdata;
  logic [9:0]  mem_addr;
  logic [63:0] mem_din;
  logic        mem_read, mem_write;
  logic [63:0] mem_dout;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        err0, err1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mem     [0:127];
  logic [63:0] ref_mem [0:127];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  bit          eq0 [$];
  bit          eq1 [$];

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(10),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_write(req0_write),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_write(req1_write),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_read  (mem_read),
    .mem_write (mem_write),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    .err0      (err0),
    .err1      (err1),
`endif
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:3]] <= mem_din;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [9:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return a[2:0] != 3'b000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_rsp(input string tag);
    bit exp_v;
    exp_v = (q0.size() != 0);
    chk({tag, "/rsp0_valid"}, 64'(rsp0_valid), 64'(exp_v));
    if (exp_v) chk({tag, "/rsp0_rdata"}, rsp0_rdata, q0.pop_front());
    exp_v = (q1.size() != 0);
    chk({tag, "/rsp1_valid"}, 64'(rsp1_valid), 64'(exp_v));
    if (exp_v) chk({tag, "/rsp1_rdata"}, rsp1_rdata, q1.pop_front());
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    exp_v = (eq0.size() != 0);
    chk({tag, "/err0"}, 64'(err0), 64'(exp_v));
    if (exp_v) void'(eq0.pop_front());
    exp_v = (eq1.size() != 0);
    chk({tag, "/err1"}, 64'(err1), 64'(exp_v));
    if (exp_v) void'(eq1.pop_front());
`endif
  endtask

  // One bus cycle: drive both ports, check the combinational grant and memory
  // strobes against the expected readies, then check responses after the edge.
  task automatic cyc(input logic v0, input logic w0, input logic [9:0] a0, input logic [63:0] d0,
                     input logic v1, input logic w1, input logic [9:0] a1, input logic [63:0] d1,
                     input logic er0, input logic er1, input string tag);
    logic        gw;
    logic [9:0]  ga;
    logic [63:0] gd;
    bit          gm;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    chk({tag, "/req0_ready"}, 64'(req0_ready), 64'(er0));
    chk({tag, "/req1_ready"}, 64'(req1_ready), 64'(er1));
    gw = 1'b0; ga = '0; gd = '0;
    if (er0) begin gw = w0; ga = a0; gd = d0; end
    if (er1) begin gw = w1; ga = a1; gd = d1; end
    gm = (er0 || er1) && misaligned(ga);
    chk({tag, "/mem_write"}, 64'(mem_write), 64'((er0 || er1) && gw && !gm));
    chk({tag, "/mem_read"},  64'(mem_read),  64'((er0 || er1) && !gw && !gm));
    chk({tag, "/mem_addr"},  64'(mem_addr),  64'(ga));
    if (er0 || er1) begin
      if (gm) begin
        if (er0) eq0.push_back(1'b1); else eq1.push_back(1'b1);
      end else if (gw) begin
        chk({tag, "/mem_din"}, mem_din, gd);
        ref_mem[ga[9:3]] = gd;
      end else if (er0) begin
        q0.push_back(ref_mem[ga[9:3]]);
      end else begin
        q1.push_back(ref_mem[ga[9:3]]);
      end
    end else begin
      chk({tag, "/mem_din_idle"}, mem_din, 64'h0);
    end
    @(posedge clk);
    #1;
    check_rsp(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 10'h0, 64'h0, 0, 0, 10'h0, 64'h0, 0, 0, tag);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 64'h0;
      ref_mem[i] = 64'h0;
    end
    reset_b = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;

    @(posedge clk); #1;
    chk("rst/req0_ready", 64'(req0_ready), 64'h0);
    chk("rst/req1_ready", 64'(req1_ready), 64'h0);
    chk("rst/rsp0_valid", 64'(rsp0_valid), 64'h0);
    chk("rst/rsp1_valid", 64'(rsp1_valid), 64'h0);
    chk("rst/rsp0_rdata", rsp0_rdata, 64'h0);
    chk("rst/rsp1_rdata", rsp1_rdata, 64'h0);
    chk("rst/mem_read",   64'(mem_read), 64'h0);
    chk("rst/mem_write",  64'(mem_write), 64'h0);
    chk("rst/mem_addr",   64'(mem_addr), 64'h0);
    chk("rst/mem_din",    mem_din, 64'h0);
    // Requests presented during reset must not be granted.
    req0_valid = 1; req1_valid = 1; #1;
    chk("rst/req0_ready_held", 64'(req0_ready), 64'h0);
    chk("rst/req1_ready_held", 64'(req1_ready), 64'h0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    reset_b = 1'b1;

    // Store then load on port 0.
    cyc(1, 1, 10'h010, 64'hDEADBEEF_CAFEF00D, 0, 0, 10'h0, 64'h0, 1, 0, "st0");
    cyc(1, 0, 10'h010, 64'h0, 0, 0, 10'h0, 64'h0, 1, 0, "ld0");
    idle("idle1");

    // Preload, then simultaneous loads: port 0 first, port 1 the next cycle.
    cyc(0, 0, 10'h0, 64'h0, 1, 1, 10'h018, 64'h1111_2222_3333_4444, 0, 1, "st1");
    cyc(1, 1, 10'h008, 64'h5555_6666_7777_8888, 0, 0, 10'h0, 64'h0, 1, 0, "st0b");
    cyc(1, 0, 10'h008, 64'h0, 1, 0, 10'h018, 64'h0, 1, 0, "sim_a");
    cyc(0, 0, 10'h0, 64'h0, 1, 0, 10'h018, 64'h0, 0, 1, "sim_b");

    // Starvation: continuous port-0 loads, port 1 wins in the 5th cycle.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 10'(i * 8), 64'h0, 1, 0, 10'h010, 64'h0,
          (i != 4), (i == 4), $sformatf("starve%0d", i));
    end
    cyc(1, 0, 10'h018, 64'h0, 0, 0, 10'h0, 64'h0, 1, 0, "starve_drop");
    cyc(1, 0, 10'h008, 64'h0, 1, 0, 10'h018, 64'h0, 1, 0, "cnt_cleared");
    cyc(0, 0, 10'h0, 64'h0, 1, 0, 10'h018, 64'h0, 0, 1, "cnt_aux");

    // Same-address conflict: port 0 store wins, port 1 reads the new value.
    cyc(1, 1, 10'h020, 64'h1, 1, 0, 10'h020, 64'h0, 1, 0, "conf_a");
    cyc(0, 0, 10'h0, 64'h0, 1, 0, 10'h020, 64'h0, 0, 1, "conf_b");
    idle("idle2");
    chk("conf/rsp1_rdata_hold", rsp1_rdata, 64'h1);

    // Reset right after a load is accepted drops the response.
    req0_valid = 1; req0_write = 0; req0_addr = 10'h010; req0_wdata = '0;
    #1;
    chk("rstfl/req0_ready", 64'(req0_ready), 64'h1);
    @(posedge clk);
    reset_b = 1'b0;
    req0_valid = 0;
    #1;
    chk("rstfl/rsp0_valid", 64'(rsp0_valid), 64'h0);
    chk("rstfl/rsp0_rdata", rsp0_rdata, 64'h0);
    chk("rstfl/rsp1_rdata", rsp1_rdata, 64'h0);
    @(posedge clk); #1;
    chk("rstfl/rsp0_valid2", 64'(rsp0_valid), 64'h0);
    reset_b = 1'b1;
    cyc(1, 0, 10'h010, 64'h0, 0, 0, 10'h0, 64'h0, 1, 0, "reissue");
    cyc(1, 0, 10'h008, 64'h0, 1, 0, 10'h020, 64'h0, 1, 0, "post_rst_cnt");
    cyc(0, 0, 10'h0, 64'h0, 1, 0, 10'h020, 64'h0, 0, 1, "post_rst_aux");

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    // Misaligned store is accepted, raises err1 and leaves memory untouched.
    cyc(0, 0, 10'h0, 64'h0, 1, 1, 10'h00C, 64'hBAD0_BAD0_BAD0_BAD0, 0, 1, "mis_st1");
    cyc(1, 0, 10'h008, 64'h0, 0, 0, 10'h0, 64'h0, 1, 0, "mis_chk");
    cyc(1, 0, 10'h00C, 64'h0, 0, 0, 10'h0, 64'h0, 1, 0, "mis_ld0");
`endif
    idle("idle_end");
    idle("idle_end2");
    chk("end/q0_empty", 64'(q0.size()), 64'h0);
    chk("end/q1_empty", 64'(q1.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
